// File: rtl/framebuffer_controller.sv
// Framebuffer RAM sequencer: parses MCU command bytes into cursor moves, pixel
// writes and screen fills, and shares the single-port RAM with scanout reads.
module framebuffer_controller #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic                  cmd_is_command,
  input  logic [7:0]            cmd_byte,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic [11:0]           scan_data,
  output logic                  scan_data_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [11:0]           mem_wdata,
  input  logic [11:0]           mem_rdata,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned X_W       = $clog2(H_RES);
  localparam int unsigned Y_W       = $clog2(V_RES);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned LAST_ADDR = H_RES * V_RES - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_X0, S_X1, S_Y0, S_Y1, S_PIX0, S_PIX1,
    S_FILL0, S_FILL1, S_FILLING, S_IGNORE
  } state_e;

  state_e                  state_q, state_d;
  logic [8:0]              fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   fill_addr_q, fill_addr_d;
  logic [7:0]              lo_q, lo_d;
  logic [11:0]             colour_q, colour_d;
  logic                    pend_q, pend_d;
  logic                    overflow_q, overflow_d;
  logic                    scan_valid_q, scan_valid_d;

  logic                    fifo_full_c, fifo_empty_c, push_c, pop_c;
  logic                    head_is_cmd_c, fill_last_c, fill_wr_c;
  logic [7:0]              head_byte_c;
  logic [15:0]             arg16_c;
  logic [X_W-1:0]          x_clamp_c;
  logic [Y_W-1:0]          y_clamp_c;

  function automatic logic [ADDR_WIDTH-1:0] lin_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
    return ADDR_WIDTH'(y) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(x);
  endfunction

  // Command FIFO control; a full FIFO still accepts a byte when it pops in the same cycle
  always_comb begin
    fifo_full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty_c  = (count_q == '0);
    pop_c         = !fifo_empty_c && !pend_q && (state_q != S_FILLING);
    push_c        = cmd_valid && (!fifo_full_c || pop_c);
    head_is_cmd_c = fifo_mem_q[rd_ptr_q][8];
    head_byte_c   = fifo_mem_q[rd_ptr_q][7:0];
    arg16_c       = {head_byte_c, lo_q};
    x_clamp_c     = (arg16_c > 16'(H_RES - 1)) ? X_W'(H_RES - 1) : X_W'(arg16_c);
    y_clamp_c     = (arg16_c > 16'(V_RES - 1)) ? Y_W'(V_RES - 1) : Y_W'(arg16_c);
    fill_wr_c     = (state_q == S_FILLING) && !scan_req;
    fill_last_c   = (fill_addr_q == ADDR_WIDTH'(LAST_ADDR));
  end

  always_ff @(posedge clock) begin
    if (push_c) fifo_mem_q[wr_ptr_q] <= {cmd_is_command, cmd_byte};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (pop_c && head_is_cmd_c) begin
      case (head_byte_c)
        8'h00:   state_d = S_IDLE;
        8'h01:   state_d = S_X0;
        8'h02:   state_d = S_Y0;
        8'h03:   state_d = S_PIX0;
        8'h04:   state_d = S_FILL0;
        default: state_d = S_IGNORE;
      endcase
    end else if (pop_c) begin
      case (state_q)
        S_X0:    state_d = S_X1;
        S_X1:    state_d = S_IDLE;
        S_Y0:    state_d = S_Y1;
        S_Y1:    state_d = S_IDLE;
        S_PIX0:  state_d = S_PIX1;
        S_PIX1:  state_d = S_PIX0;
        S_FILL0: state_d = S_FILL1;
        S_FILL1: state_d = S_FILLING;
        default: state_d = state_q;
      endcase
    end else if (fill_wr_c && fill_last_c) begin
      state_d = S_IDLE;
    end
  end

  // Datapath: FIFO pointers, cursor, argument capture, pending write and fill address
  always_comb begin
    wr_ptr_d     = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    overflow_d   = overflow_q | (cmd_valid && !push_c);
    scan_valid_d = scan_req;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    fill_addr_d  = fill_addr_q;
    lo_d         = lo_q;
    colour_d     = colour_q;
    pend_d       = pend_q;

    if (pop_c && !head_is_cmd_c) begin
      case (state_q)
        S_X0, S_Y0, S_PIX0, S_FILL0: lo_d = head_byte_c;
        S_X1: begin
          x_d    = x_clamp_c;
          addr_d = lin_addr(x_clamp_c, y_q);
        end
        S_Y1: begin
          y_d    = y_clamp_c;
          addr_d = lin_addr(x_q, y_clamp_c);
        end
        S_PIX1: begin
          colour_d = {lo_q, head_byte_c[3:0]};
          pend_d   = 1'b1;
        end
        S_FILL1: begin
          colour_d    = {lo_q, head_byte_c[3:0]};
          fill_addr_d = '0;
        end
        default: ;
      endcase
    end

    // Pixel retires on the first scan-free cycle, then the cursor steps in raster order
    if (pend_q && !scan_req) begin
      pend_d = 1'b0;
      if (x_q == X_W'(H_RES - 1)) begin
        x_d = '0;
        if (y_q == Y_W'(V_RES - 1)) begin
          y_d    = '0;
          addr_d = '0;
        end else begin
          y_d    = y_q + Y_W'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end else begin
        x_d    = x_q + X_W'(1);
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end

    if (fill_wr_c && !fill_last_c) fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      fill_addr_q  <= '0;
      lo_q         <= '0;
      colour_q     <= '0;
      pend_q       <= 1'b0;
      overflow_q   <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      fill_addr_q  <= fill_addr_d;
      lo_q         <= lo_d;
      colour_q     <= colour_d;
      pend_q       <= pend_d;
      overflow_q   <= overflow_d;
      scan_valid_q <= scan_valid_d;
    end
  end

  // RAM port arbitration: scanout reads always take the cycle
  always_comb begin
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    if (scan_req) begin
      mem_en   = 1'b1;
      mem_addr = scan_addr;
    end else if (pend_q) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = addr_q;
      mem_wdata = colour_q;
    end else if (state_q == S_FILLING) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fill_addr_q;
      mem_wdata = colour_q;
    end
    scan_data_valid = scan_valid_q;
    scan_data       = scan_valid_q ? mem_rdata : 12'h000;
    busy            = !fifo_empty_c || pend_q || (state_q == S_FILLING);
    overflow        = overflow_q;
  end

endmodule

// File: tb/tb_framebuffer_controller.sv
// Scoreboard bench for framebuffer_controller: a byte-level command model predicts
// RAM writes; a monitor checks writes and scanout read data as the DUT presents them.
module tb_framebuffer_controller;

  localparam int H    = 64;
  localparam int V    = 48;
  localparam int AW   = 12;
  localparam int FD   = 8;
  localparam int NPIX = H * V;

  logic          clock, reset, cmd_valid, cmd_is_command, scan_req;
  logic [7:0]    cmd_byte;
  logic [AW-1:0] scan_addr, mem_addr;
  logic [11:0]   scan_data, mem_wdata, mem_rdata;
  logic          scan_data_valid, mem_en, mem_we, busy, overflow;

  framebuffer_controller #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_is_command(cmd_is_command),
    .cmd_byte(cmd_byte), .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data),
    .scan_data_valid(scan_data_valid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .overflow(overflow)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  longint      wq[$];
  logic [11:0] sq[$];
  logic [11:0] ram [2**AW];
  logic        scan_prev;
  int          scan_mode, scan_hold, cyc;
  int          m_cmd, m_x, m_y;
  logic [7:0]  m_args[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: commands collect arguments, completed arguments produce writes
  function automatic void exp_write(input int addr, input int data);
    wq.push_back((longint'(addr) << 12) | longint'(data));
  endfunction

  function automatic void model_reset();
    m_cmd = 0; m_x = 0; m_y = 0;
    m_args.delete();
  endfunction

  function automatic void model_byte(input bit c, input logic [7:0] b);
    int v;
    if (c) begin
      m_args.delete();
      m_cmd = (b <= 8'd4) ? int'(b) : 99;
      return;
    end
    case (m_cmd)
      1, 2: begin
        m_args.push_back(b);
        if (m_args.size() == 2) begin
          v = int'({m_args[1], m_args[0]});
          if (m_cmd == 1) m_x = (v > H - 1) ? H - 1 : v;
          else            m_y = (v > V - 1) ? V - 1 : v;
          m_cmd = 0;
          m_args.delete();
        end
      end
      3: begin
        m_args.push_back(b);
        if (m_args.size() == 2) begin
          exp_write(m_y * H + m_x, int'({m_args[0], m_args[1][3:0]}));
          m_x++;
          if (m_x == H) begin
            m_x = 0;
            m_y++;
            if (m_y == V) m_y = 0;
          end
          m_args.delete();
        end
      end
      4: begin
        m_args.push_back(b);
        if (m_args.size() == 2) begin
          v = int'({m_args[0], m_args[1][3:0]});
          for (int a = 0; a < NPIX; a++) exp_write(a, v);
          m_cmd = 0;
          m_args.delete();
        end
      end
      default: ;
    endcase
  endfunction

  // Behavioural RAM with one-cycle read latency; records what each scan read must return
  always @(posedge clock) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    if (reset) begin
      scan_prev <= 1'b0;
      sq.delete();
    end else begin
      scan_prev <= scan_req;
      if (scan_req) sq.push_back(ram[scan_addr]);
    end
  end

  // Monitor: every RAM write and every scan result is popped and compared
  initial begin
    longint e;
    logic [11:0] s;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (scan_req) begin
          chk(mem_en && !mem_we, "scan_read_port", {mem_en, mem_we}, 2);
          chk(mem_addr == scan_addr, "scan_read_addr", mem_addr, scan_addr);
        end
        if (mem_en && mem_we) begin
          n_writes++;
          if (wq.size() == 0) chk(1'b0, "unexpected_write", mem_addr, 0);
          else begin
            e = wq.pop_front();
            chk(mem_addr == AW'(e >> 12), "write_addr", mem_addr, e >> 12);
            chk(mem_wdata == 12'(e), "write_data", mem_wdata, e & 'hFFF);
          end
        end
        chk(scan_data_valid == scan_prev, "scan_valid_timing", scan_data_valid, scan_prev);
        if (scan_prev && sq.size() != 0) begin
          s = sq.pop_front();
          if (scan_data_valid) chk(scan_data == s, "scan_data", scan_data, s);
        end
      end
    end
  end

  task automatic step(input bit v, input bit c, input logic [7:0] b);
    @(posedge clock);
    #1;
    cmd_valid = v; cmd_is_command = c; cmd_byte = b;
    if (scan_hold > 0) begin
      scan_req = 1'b1;
      scan_hold--;
    end else begin
      case (scan_mode)
        1:       scan_req = (cyc % 4 == 0);
        2:       scan_req = ($urandom_range(0, 3) == 0);
        default: scan_req = 1'b0;
      endcase
    end
    scan_addr = AW'($urandom_range(0, NPIX - 1));
    cyc++;
  endtask

  task automatic send(input bit c, input logic [7:0] b);
    step(1'b1, c, b);
    model_byte(c, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_quiet(input int limit);
    int n;
    n = 0;
    idle(1);
    while (busy && n < limit) begin
      idle(1);
      n++;
    end
    if (n >= limit) chk(1'b0, "busy_timeout", n, limit);
  endtask

  task automatic rand_burst();
    int len, r, k;
    logic [7:0] b;
    len = $urandom_range(1, 8);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        k = $urandom_range(0, 39);
        if (k == 0)       b = 8'h04;
        else if (k < 6)   b = 8'h00;
        else if (k < 12)  b = 8'h01;
        else if (k < 18)  b = 8'h02;
        else if (k < 32)  b = 8'h03;
        else              b = 8'($urandom_range(5, 255));
        send(1'b1, b);
      end else begin
        send(1'b0, 8'($urandom_range(0, 255)));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, bad, n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_is_command = 1'b0; cmd_byte = 8'h00;
    scan_req = 1'b0; scan_addr = '0; scan_mode = 0; scan_hold = 0; cyc = 0;
    model_reset();
    #2;
    chk(mem_en == 1'b0, "reset_mem_en", mem_en, 0);
    chk(mem_we == 1'b0, "reset_mem_we", mem_we, 0);
    chk(mem_addr == '0, "reset_mem_addr", mem_addr, 0);
    chk(mem_wdata == '0, "reset_mem_wdata", mem_wdata, 0);
    chk(scan_data_valid == 1'b0, "reset_scan_valid", scan_data_valid, 0);
    chk(scan_data == '0, "reset_scan_data", scan_data, 0);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(overflow == 1'b0, "reset_overflow", overflow, 0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;

    // Cursor setup then one pixel, then a second pixel to show x advanced to 11
    send(1, 8'h01); send(0, 8'h0A); send(0, 8'h00);
    send(1, 8'h02); send(0, 8'h05); send(0, 8'h00);
    wait_quiet(100);
    send(1, 8'h03); send(0, 8'hF0); send(0, 8'h0F);
    wait_quiet(100);
    send(0, 8'h11); send(0, 8'h02);
    wait_quiet(100);

    // Last pixel of the frame, then wrap to address 0
    send(1, 8'h01); send(0, 8'h3F); send(0, 8'h00);
    send(1, 8'h02); send(0, 8'h2F); send(0, 8'h00);
    wait_quiet(100);
    send(1, 8'h03); send(0, 8'h12); send(0, 8'h34); send(0, 8'h56); send(0, 8'h78);
    wait_quiet(100);

    // Clamped x, aborted SET_Y, then a pixel at the unchanged row
    send(1, 8'h01); send(0, 8'hFF); send(0, 8'hFF);
    send(1, 8'h02); send(0, 8'h07);
    send(1, 8'h03); send(0, 8'hAB); send(0, 8'hCD);
    wait_quiet(100);

    // Pixel write held off by five consecutive scan reads
    send(1, 8'h03); send(0, 8'h9A);
    scan_hold = 5;
    send(0, 8'hBC);
    wait_quiet(100);
    chk(wq.size() == 0, "stalled_write_retired", wq.size(), 0);

    // Full-screen fill with a scan read every fourth cycle
    scan_mode = 1;
    w0 = n_writes;
    send(1, 8'h04); send(0, 8'h12); send(0, 8'h03);
    idle(20);
    chk(busy == 1'b1, "busy_during_fill", busy, 1);
    n = 0;
    while (wq.size() > 0 && n < 8000) begin
      idle(1);
      n++;
    end
    chk(n < 8000, "fill_timeout", n, 8000);
    idle(1);
    chk(busy == 1'b0, "busy_after_fill", busy, 0);
    chk(n_writes - w0 == NPIX, "fill_write_count", n_writes - w0, NPIX);
    bad = 0;
    for (int a = 0; a < NPIX; a++) if (ram[a] != 12'h123) bad++;
    chk(bad == 0, "fill_coverage", bad, 0);
    scan_mode = 0;

    // Ten back-to-back bytes while filling: eight fit, the last two are dropped
    send(1, 8'h04); send(0, 8'h45); send(0, 8'h06);
    idle(5);
    send(1, 8'h03); send(0, 8'h11); send(0, 8'h21); send(0, 8'h31);
    send(0, 8'h41); send(0, 8'h51); send(0, 8'h61); send(0, 8'h71);
    step(1, 0, 8'h0C); step(1, 0, 8'h0D);
    idle(1);
    chk(overflow == 1'b1, "overflow_set", overflow, 1);
    wait_quiet(20000);
    chk(overflow == 1'b1, "overflow_sticky", overflow, 1);
    chk(wq.size() == 0, "overflow_writes_done", wq.size(), 0);

    // Asynchronous reset in the middle of a fill
    send(1, 8'h04); send(0, 8'h0A); send(0, 8'h0B);
    idle(30);
    chk(busy == 1'b1, "fill_running_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk(mem_en == 1'b0, "reset_midfill_mem_en", mem_en, 0);
    chk(mem_we == 1'b0, "reset_midfill_mem_we", mem_we, 0);
    chk(overflow == 1'b0, "reset_midfill_overflow", overflow, 0);
    chk(busy == 1'b0, "reset_midfill_busy", busy, 0);
    wq.delete();
    model_reset();
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    idle(20);
    chk(busy == 1'b0, "idle_after_reset", busy, 0);

    // Randomised command traffic with random scan interference
    for (int i = 0; i < 60; i++) begin
      scan_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      wait_quiet(20000);
      rand_burst();
    end
    wait_quiet(20000);
    chk(wq.size() == 0, "final_write_queue_empty", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_controller.md
Name: framebuffer_controller

Overview:
- Sequences all framebuffer RAM traffic for the GPU between the MCU byte bus and VGA scanout.
- Parses command/data bytes from the MCU bus receiver into cursor updates, pixel writes and full-screen fills.
- Arbitrates the single-port framebuffer RAM between these writes and scanout reads; scanout always wins.
- Sits between the MCU bus receiver, the framebuffer RAM and the colour output stage.

Parameters:
H_RES, 640, pixels per line
V_RES, 480, lines per frame
ADDR_WIDTH, 19, framebuffer address width (must hold H_RES*V_RES-1)
FIFO_DEPTH, 8, command byte FIFO entries (power of two)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  one-cycle strobe, byte present on cmd_byte
cmd_is_command  in  1  1 = command byte, 0 = data byte
cmd_byte  in  8  byte from MCU bus
scan_req  in  1  scanout read request this cycle
scan_addr  in  ADDR_WIDTH  scanout pixel address
scan_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}
scan_data_valid  out  1  scan_data valid
mem_en  out  1  RAM access this cycle
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  12  RAM write data
mem_rdata  in  12  RAM read data, valid 1 cycle after read
busy  out  1  FIFO non-empty, write pending, or fill active
overflow  out  1  sticky: byte dropped on full FIFO

Behaviour:
- Reset values: all outputs 0; FIFO empty; cursor x=y=0; linear address 0; state IDLE; no pending write.
- FIFO: 9-bit entries {is_command, byte}. Push on cmd_valid when not full.
- cmd_valid with FIFO full: byte dropped, overflow set. Overflow clears only on reset.
- Simultaneous push and pop when full: push accepted.
- Parser pops one entry per cycle, only when no write is pending and state != FILLING.
- Command bytes in any state except FILLING abort the current command. Partial arguments are discarded; x, y and colour are unchanged.
- Commands:
  - 0x00 NOP.
  - 0x01 SET_X: 2 data bytes, LSB first.
  - 0x02 SET_Y: 2 data bytes, LSB first.
  - 0x03 WRITE_PIXELS: pixel stream.
  - 0x04 FILL: 2 colour bytes, then fill.
  - Any other command: state IGNORE; data bytes discarded until next command.
- States: IDLE, X0, X1, Y0, Y1, PIX0, PIX1, FILL0, FILL1, FILLING, IGNORE.
- Data byte in IDLE is discarded.
- Coordinate update: the 16-bit value is clamped to H_RES-1 (x) or V_RES-1 (y).
- Linear address = y*H_RES + x, recomputed in the cycle the last argument byte is consumed.
- Pixel format:
  - byte0 = {R[3:0],G[3:0]}.
  - byte1 low nibble = B; high nibble ignored.
- PIX1 consumption: creates a pending write {address, colour}, then returns to PIX0 for the next pixel.
- Pending write retire: the write is issued in the first cycle with scan_req=0.
- Cursor advance after each retired pixel: x+1 and address+1.
  - x = H_RES-1: x wraps to 0 and y increments.
  - y = V_RES-1 as well: y wraps to 0 and address wraps to 0.
- FILL1 consumption: enters FILLING at address 0.
  - Writes the colour once per cycle when scan_req=0, address 0 to H_RES*V_RES-1.
  - After the last write returns to IDLE. Cursor unchanged.
  - FIFO keeps accepting bytes during the fill.
- Arbitration:
  - scan_req=1: mem_en=1, mem_we=0, mem_addr=scan_addr; any write stalls.
  - Otherwise, with a pending write or fill: mem_en=1, mem_we=1.
  - Otherwise: mem_en=0.
- Memory outputs are combinational from the registered state. No write is ever lost to a scan collision.
- Scan read timing: scan_data_valid=1 and scan_data=mem_rdata exactly 1 cycle after each scan_req cycle. Back-to-back requests give back-to-back valid data.
- Reset asserted mid-fill or mid-command: immediate return to reset values. No further writes until new commands arrive.

Test Plan:
- Bytes cmd 0x01, 0x0A, 0x00, cmd 0x02, 0x05, 0x00, cmd 0x03, 0xF0, 0x0F -> one write, mem_addr=3210, mem_wdata=0xF0F; cursor x=11.
- SET_X=639, SET_Y=479, then 2 pixels -> writes at addr 307199 then addr 0.
- SET_X with data 0xFFFF -> x=639. Command byte after 1 of 2 SET_Y bytes -> y unchanged.
- Pixel write pending while scan_req held 5 cycles -> 5 reads, then the write retires. scan_data_valid trails each scan_req by 1 cycle and matches the RAM model.
- FILL 0x12,0x03 with scan_req 1 cycle in 4 -> exactly 307200 writes of 0x123 covering every address once; busy falls after the last write.
- 10 bytes in consecutive cycles during FILLING (FIFO_DEPTH=8) -> 8 stored, overflow=1 and stays 1. Reset mid-fill -> mem_en=0, overflow=0 asynchronously.
